// File: rtl/fetch_redirect_if.sv
// Fetch-stage bundle: branch decision in, IMEM address/data, IF/ID outputs, flushes and status.
// master = the surrounding pipeline/memory; slave = the fetch_redirect unit.
interface fetch_redirect_if #(
    parameter int unsigned N     = 64,
    parameter int unsigned CNT_W = 16
);
    logic             PCSrc_M;
    logic [N-1:0]     PCBranch_M;
    logic             stall_F;
    logic [N-1:0]     imem_addr_F;
    logic [31:0]      imem_data_F;
    logic [31:0]      instr_D;
    logic [N-1:0]     pc_D;
    logic             valid_D;
    logic             flush_E;
    logic             flush_M;
    logic             misalign_err;
    logic [CNT_W-1:0] taken_count;

    modport master (
        output PCSrc_M, PCBranch_M, stall_F, imem_data_F,
        input  imem_addr_F, instr_D, pc_D, valid_D, flush_E, flush_M,
        input  misalign_err, taken_count
    );

    modport slave (
        input  PCSrc_M, PCBranch_M, stall_F, imem_data_F,
        output imem_addr_F, instr_D, pc_D, valid_D, flush_E, flush_M,
        output misalign_err, taken_count
    );
endinterface

// File: rtl/fetch_redirect.sv
// Fetch-stage PC sequencer and IF/ID register. A taken branch from the memory stage
// redirects the PC (beating any stall), squashes IF/ID and flushes ID/EX and EX/MEM.
// Also keeps a sticky misaligned-target flag and a saturating taken-branch counter.
module fetch_redirect #(
    parameter int unsigned    N        = 64,
    parameter logic [N-1:0]   RESET_PC = '0,
    parameter int unsigned    CNT_W    = 16
) (
    input logic           clk,
    input logic           reset,
    fetch_redirect_if.slave bus
);
    localparam logic [N-1:0]     PcStep  = {{(N-3){1'b0}}, 3'd4};
    localparam logic [CNT_W-1:0] CntOne  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CntMax  = '1;

    logic [N-1:0]     pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [N-1:0]     pcd_q, pcd_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next state: redirect beats stall, stall beats sequential fetch.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pcd_d   = pcd_q;
        valid_d = valid_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        if (bus.PCSrc_M) begin
            // Low bits are forced to zero; a misaligned target is still followed.
            pc_d    = {bus.PCBranch_M[N-1:2], 2'b00};
            instr_d = '0;
            pcd_d   = '0;
            valid_d = 1'b0;
            if (bus.PCBranch_M[1:0] != 2'b00) begin
                err_d = 1'b1;
            end
            if (cnt_q != CntMax) begin
                cnt_d = cnt_q + CntOne;
            end
        end else if (!bus.stall_F) begin
            pc_d    = pc_q + PcStep;
            instr_d = bus.imem_data_F;
            pcd_d   = pc_q;
            valid_d = 1'b1;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= '0;
            pcd_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs; flushes follow the branch decision combinationally, even during reset.
    always_comb begin
        bus.imem_addr_F  = pc_q;
        bus.instr_D      = instr_q;
        bus.pc_D         = pcd_q;
        bus.valid_D      = valid_q;
        bus.misalign_err = err_q;
        bus.taken_count  = cnt_q;
        bus.flush_E      = bus.PCSrc_M;
        bus.flush_M      = bus.PCSrc_M;
    end
endmodule

// File: tb/tb_fetch_redirect.sv
// Bench for fetch_redirect: directed scenarios then random traffic, checked against a
// behavioural model. A second instance with a 2-bit counter checks saturation.
module tb_fetch_redirect;
    logic clk;
    logic reset;

    fetch_redirect_if #(.N(64), .CNT_W(16)) bus ();
    fetch_redirect_if #(.N(64), .CNT_W(2))  bus_s ();

    fetch_redirect #(.N(64), .RESET_PC(64'h0), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    fetch_redirect #(.N(64), .RESET_PC(64'h0), .CNT_W(2)) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    bit const_mode = 1'b1;

    // Behavioural model state
    logic [63:0] m_pc;
    logic [31:0] m_instr;
    logic [63:0] m_pcd;
    bit          m_valid;
    bit          m_err;
    int          m_taken;

    function automatic logic [31:0] imem_fn(input logic [63:0] a);
        if (const_mode) return 32'h8B020020;
        return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h0F1E_2D3C;
    endfunction

    always_comb bus.imem_data_F   = imem_fn(bus.imem_addr_F);
    always_comb bus_s.imem_data_F = imem_fn(bus_s.imem_addr_F);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_reset();
        m_pc = 64'h0; m_instr = 32'h0; m_pcd = 64'h0; m_valid = 0; m_err = 0; m_taken = 0;
    endtask

    task automatic check_all(input string where);
        chk({where, ":addr"},   bus.imem_addr_F, m_pc);
        chk({where, ":instr"},  {32'h0, bus.instr_D}, {32'h0, m_instr});
        chk({where, ":pc_D"},   bus.pc_D, m_pcd);
        chk({where, ":valid"},  {63'h0, bus.valid_D}, {63'h0, m_valid});
        chk({where, ":err"},    {63'h0, bus.misalign_err}, {63'h0, m_err});
        chk({where, ":cnt16"},  {48'h0, bus.taken_count}, 64'(sat(m_taken, 65535)));
        chk({where, ":cnt2"},   {62'h0, bus_s.taken_count}, 64'(sat(m_taken, 3)));
        chk({where, ":addr_s"}, bus_s.imem_addr_F, m_pc);
    endtask

    task automatic drive(input bit src, input logic [63:0] tgt, input bit stl);
        bus.PCSrc_M = src;   bus.PCBranch_M = tgt;   bus.stall_F = stl;
        bus_s.PCSrc_M = src; bus_s.PCBranch_M = tgt; bus_s.stall_F = stl;
    endtask

    // One clock: drive at negedge, check flushes, clock, update model, check state.
    task automatic step(input bit src, input logic [63:0] tgt, input bit stl);
        logic [31:0] md;
        drive(src, tgt, stl);
        #1;
        chk("flush_E", {63'h0, bus.flush_E}, {63'h0, src});
        chk("flush_M", {63'h0, bus.flush_M}, {63'h0, src});
        md = imem_fn(m_pc);
        @(posedge clk);
        if (src) begin
            m_pc = {tgt[63:2], 2'b00};
            m_instr = 32'h0; m_pcd = 64'h0; m_valid = 0;
            if (tgt[1:0] != 2'b00) m_err = 1;
            m_taken = m_taken + 1;
        end else if (!stl) begin
            m_instr = md; m_pcd = m_pc; m_valid = 1;
            m_pc = m_pc + 64'd4;
        end
        #1;
        check_all("step");
        @(negedge clk);
    endtask

    // Reset applied between edges, optionally while a redirect is being signalled.
    task automatic mid_reset(input bit src);
        #2;
        drive(src, 64'h1234, 1'b0);
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        chk("rst_flush_E", {63'h0, bus.flush_E}, {63'h0, src});
        chk("rst_flush_M", {63'h0, bus.flush_M}, {63'h0, src});
        drive(1'b0, 64'h0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 64'h0, 1'b0);
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // Sequential fetch with constant instruction word
        step(0, 0, 0);
        chk("seq_addr1", bus.imem_addr_F, 64'h4);
        chk("seq_instr1", {32'h0, bus.instr_D}, 64'h8B020020);
        chk("seq_valid1", {63'h0, bus.valid_D}, 64'h1);
        chk("seq_pcD1", bus.pc_D, 64'h0);
        for (int i = 0; i < 15; i++) step(0, 0, 0);
        chk("seq_at40", bus.imem_addr_F, 64'h40);

        // Taken branch from PC=0x40 to 0x100
        step(1, 64'h100, 0);
        chk("br_addr", bus.imem_addr_F, 64'h100);
        chk("br_valid", {63'h0, bus.valid_D}, 64'h0);
        chk("br_cnt", {48'h0, bus.taken_count}, 64'h1);
        step(0, 0, 0);
        chk("br_pcD", bus.pc_D, 64'h100);
        chk("br_valid2", {63'h0, bus.valid_D}, 64'h1);

        // Stall at PC=0x20, then redirect during stall
        step(1, 64'h1C, 0);
        step(0, 0, 0);
        chk("stall_start", bus.imem_addr_F, 64'h20);
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        chk("stall_hold_addr", bus.imem_addr_F, 64'h20);
        chk("stall_hold_pcD", bus.pc_D, 64'h1C);
        step(1, 64'h200, 1);
        chk("stall_redirect", bus.imem_addr_F, 64'h200);
        chk("stall_redir_valid", {63'h0, bus.valid_D}, 64'h0);

        // Misaligned target: followed with low bits cleared, sticky flag
        step(1, 64'h102, 0);
        chk("mis_addr", bus.imem_addr_F, 64'h100);
        chk("mis_err", {63'h0, bus.misalign_err}, 64'h1);
        step(0, 0, 0);
        step(1, 64'h300, 0);
        chk("mis_sticky", {63'h0, bus.misalign_err}, 64'h1);

        // Counter saturation on back-to-back redirects after a fresh reset
        mid_reset(1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1, 64'h400 + 64'(i * 16), 0);
            chk("sat_cnt2", {62'h0, bus_s.taken_count}, (i < 3) ? 64'(i + 1) : 64'h3);
            chk("b2b_addr", bus.imem_addr_F, 64'h400 + 64'(i * 16));
        end
        chk("sat_cnt16", {48'h0, bus.taken_count}, 64'h5);

        // PC wrap at the top of the address space
        step(1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
        step(0, 0, 0);
        chk("wrap_addr", bus.imem_addr_F, 64'h0);
        chk("wrap_pcD", bus.pc_D, 64'hFFFF_FFFF_FFFF_FFFC);

        // Random traffic with address-dependent instruction words
        const_mode = 1'b0;
        for (int i = 0; i < 400; i++) begin
            bit src, stl;
            logic [63:0] tgt;
            src = ($urandom_range(0, 4) == 0);
            stl = ($urandom_range(0, 3) == 0);
            tgt = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            step(src, tgt, stl);
            if (i == 200) mid_reset(1'b0);
        end

        // Reset mid-cycle after random traffic
        mid_reset(1'b1);
        step(0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
